// File: rtl/execute.sv
// execute: RV32I EX stage with operand forwarding, ALU, branch resolution and EX/MEM pipeline register.
package decode_pkg;
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [1:0]  ALUOp;
        logic        ALUSrc;
        logic        Branch;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
    } id_ex_t;
endpackage

package execute_pkg;
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
    } ex_mem_t;
endpackage

module execute
    import decode_pkg::*;
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        flush,
    input  id_ex_t      id_ex,
    input  logic [31:0] wb_data,
    input  logic [4:0]  wb_addr,
    input  logic        wb_we,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output ex_mem_t     ex_mem
);
    ex_mem_t     r_ex_mem;
    logic [31:0] w_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [4:0]  w_shamt;
    logic        w_alt;
    logic        w_cmp;
    logic        w_em_fwd_ok;
    logic        w_wb_fwd_ok;

    assign ex_mem = r_ex_mem;

    // A load result is not yet in alu_result, so ex_mem only forwards non-load writes.
    assign w_em_fwd_ok = r_ex_mem.RegWrite && !r_ex_mem.MemRead && r_ex_mem.rd != 5'd0;
    assign w_wb_fwd_ok = wb_we && wb_addr != 5'd0;

    assign w_a = (w_em_fwd_ok && r_ex_mem.rd == id_ex.rs1) ? r_ex_mem.alu_result :
                 (w_wb_fwd_ok && wb_addr == id_ex.rs1)     ? wb_data : id_ex.rs1_data;
    assign w_fwd_b = (w_em_fwd_ok && r_ex_mem.rd == id_ex.rs2) ? r_ex_mem.alu_result :
                     (w_wb_fwd_ok && wb_addr == id_ex.rs2)     ? wb_data : id_ex.rs2_data;
    assign w_b     = id_ex.ALUSrc ? id_ex.imm : w_fwd_b;
    assign w_shamt = w_b[4:0];

    // I-type only honours funct7_5 for SRAI; R-type also uses it for SUB.
    assign w_alt = id_ex.funct7_5 && (id_ex.ALUOp == 2'b10 || id_ex.funct3 == 3'b101);

    always_comb begin
        w_alu = w_a + w_b;
        if (id_ex.ALUOp == 2'b01)
            w_alu = w_a - w_b;
        else if (id_ex.ALUOp[1]) begin
            case (id_ex.funct3)
                3'b000:  w_alu = w_alt ? w_a - w_b : w_a + w_b;
                3'b001:  w_alu = w_a << w_shamt;
                3'b010:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
                3'b011:  w_alu = {31'd0, w_a < w_b};
                3'b100:  w_alu = w_a ^ w_b;
                3'b101:  w_alu = w_alt ? 32'($signed(w_a) >>> w_shamt) : w_a >> w_shamt;
                3'b110:  w_alu = w_a | w_b;
                default: w_alu = w_a & w_b;
            endcase
        end
    end

    always_comb begin
        case (id_ex.funct3)
            3'b000:  w_cmp = w_a == w_fwd_b;
            3'b001:  w_cmp = w_a != w_fwd_b;
            3'b100:  w_cmp = $signed(w_a) < $signed(w_fwd_b);
            3'b101:  w_cmp = $signed(w_a) >= $signed(w_fwd_b);
            3'b110:  w_cmp = w_a < w_fwd_b;
            3'b111:  w_cmp = w_a >= w_fwd_b;
            default: w_cmp = 1'b0;
        endcase
    end

    assign branch_taken  = id_ex.Branch && w_cmp;
    assign branch_target = id_ex.pc_plus4 - 32'd4 + id_ex.imm;

    always_ff @(posedge clk) begin
        if (reset || flush)
            r_ex_mem <= '0;
        else if (we)
            r_ex_mem <= '{
                pc_plus4:   id_ex.pc_plus4,
                alu_result: w_alu,
                store_data: w_fwd_b,
                rd:         id_ex.rd,
                funct3:     id_ex.funct3,
                RegWrite:   id_ex.RegWrite,
                MemRead:    id_ex.MemRead,
                MemWrite:   id_ex.MemWrite,
                MemToReg:   id_ex.MemToReg
            };
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed scoreboard bench for the execute stage.
module tb_execute;
    import decode_pkg::*;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b1;
    logic        flush = 1'b0;
    id_ex_t      id_ex = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  wb_addr = '0;
    logic        wb_we = 1'b0;
    logic        branch_taken;
    logic [31:0] branch_target;
    ex_mem_t     ex_mem;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string   tag;
        ex_mem_t exp;
    } sb_item_t;
    sb_item_t sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] res;
    } alu_vec_t;

    alu_vec_t tv[14] = '{
        '{2'd2, 3'd0, 1'b0, 32'd5,          32'd7,          32'd12},
        '{2'd2, 3'd0, 1'b1, 32'd5,          32'd7,          32'hFFFF_FFFE},
        '{2'd2, 3'd1, 1'b0, 32'd1,          32'd33,         32'd2},
        '{2'd2, 3'd2, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1},
        '{2'd2, 3'd3, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0},
        '{2'd2, 3'd4, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0},
        '{2'd2, 3'd5, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000},
        '{2'd2, 3'd5, 1'b1, 32'h8000_0000,  32'd36,         32'hF800_0000},
        '{2'd2, 3'd6, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0},
        '{2'd2, 3'd7, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000},
        '{2'd0, 3'd7, 1'b1, 32'd5,          32'd7,          32'd12},
        '{2'd1, 3'd0, 1'b0, 32'd5,          32'd7,          32'hFFFF_FFFE},
        '{2'd3, 3'd0, 1'b1, 32'd5,          32'd7,          32'd12},
        '{2'd3, 3'd5, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000}
    };

    execute dut (
        .clk(clk), .reset(reset), .we(we), .flush(flush), .id_ex(id_ex),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
        .branch_taken(branch_taken), .branch_target(branch_target), .ex_mem(ex_mem)
    );

    always #5 clk = ~clk;

    function automatic id_ex_t mk(input logic [31:0] pc, d1, d2, imm,
                                  input logic [4:0] rs1, rs2, rd,
                                  input logic [2:0] f3, input logic f7, input logic [1:0] op,
                                  input logic src, br, rw, mr, mw, m2r);
        return '{pc_plus4: pc, rs1_data: d1, rs2_data: d2, imm: imm, rs1: rs1, rs2: rs2,
                 rd: rd, funct3: f3, funct7_5: f7, ALUOp: op, ALUSrc: src, Branch: br,
                 RegWrite: rw, MemRead: mr, MemWrite: mw, MemToReg: m2r};
    endfunction

    function automatic ex_mem_t em(input logic [31:0] pc, alu, sd, input logic [4:0] rd,
                                   input logic [2:0] f3, input logic rw, mr, mw, m2r);
        return '{pc_plus4: pc, alu_result: alu, store_data: sd, rd: rd, funct3: f3,
                 RegWrite: rw, MemRead: mr, MemWrite: mw, MemToReg: m2r};
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_em(input string tag, input ex_mem_t obs, input ex_mem_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: ex_mem got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input ex_mem_t exp);
        sb_item_t it;
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1;
        it = sb.pop_front();
        chk_em(it.tag, ex_mem, it.exp);
    endtask

    task automatic br(input string tag, input logic [31:0] d1, d2, input logic [2:0] f3,
                      input logic b, input logic exp);
        id_ex = mk(32'h104, d1, d2, 32'hFFFF_FFF8, 5'd23, 5'd24, 5'd0, f3, 1'b0, 2'd1,
                   1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk32(tag, {31'd0, branch_taken}, {31'd0, exp});
    endtask

    initial begin
        ex_mem_t held;
        id_ex = mk(32'h40, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 2'd2,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_em("reset", ex_mem, '0);
        reset = 1'b0;

        id_ex = mk(32'h10, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 2'd2,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("add_x3", em(32'h10, 32'd12, 32'd7, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        id_ex = mk(32'h14, 32'd0, 32'd0, 32'd100, 5'd0, 5'd0, 5'd1, 3'd0, 1'b0, 2'd3,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("addi_x1", em(32'h14, 32'd100, 32'd0, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd50;
        id_ex = mk(32'h18, 32'd9, 32'd0, 32'd0, 5'd1, 5'd0, 5'd4, 3'd0, 1'b1, 2'd2,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fwd_exmem_wins", em(32'h18, 32'd100, 32'd0, 5'd4, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        id_ex = mk(32'h1C, 32'd0, 32'd0, 32'd100, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 2'd3,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("addi_x0", em(32'h1C, 32'd100, 32'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        id_ex = mk(32'h20, 32'd9, 32'd0, 32'd0, 5'd1, 5'd0, 5'd4, 3'd0, 1'b1, 2'd2,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fwd_wb_rd0", em(32'h20, 32'd50, 32'd0, 5'd4, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        wb_we = 1'b0;

        id_ex = mk(32'h24, 32'd3, 32'd0, 32'hFFFF_FFFF, 5'd5, 5'd0, 5'd7, 3'd0, 1'b1, 2'd3,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("addi_neg", em(32'h24, 32'd2, 32'd0, 5'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        id_ex = mk(32'h28, 32'h8000_0000, 32'd0, 32'h404, 5'd6, 5'd0, 5'd8, 3'd5, 1'b1, 2'd3,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("srai", em(32'h28, 32'hF800_0000, 32'd0, 5'd8, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 14; i++) begin
            id_ex = mk(32'h80 + 32'(4 * i), tv[i].d1, tv[i].d2, 32'd0, 5'd20, 5'd21, 5'd22,
                       tv[i].f3, tv[i].f7, tv[i].op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step($sformatf("alu_%0d", i),
                 em(32'h80 + 32'(4 * i), tv[i].res, tv[i].d2, 5'd22, tv[i].f3,
                    1'b1, 1'b0, 1'b0, 1'b0));
        end

        id_ex = mk(32'h104, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 5'd23, 5'd24, 5'd0, 3'd4,
                   1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk32("blt_taken", {31'd0, branch_taken}, 32'd1);
        chk32("blt_target", branch_target, 32'hF8);
        step("blt_exmem", em(32'h104, 32'hFFFF_FFFE, 32'd1, 5'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0));

        br("bltu", 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b1, 1'b0);
        br("beq", 32'd5, 32'd5, 3'd0, 1'b1, 1'b1);
        br("bne", 32'd5, 32'd5, 3'd1, 1'b1, 1'b0);
        br("bge", 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b1, 1'b0);
        br("bgeu", 32'hFFFF_FFFF, 32'd1, 3'd7, 1'b1, 1'b1);
        br("f3_010", 32'd5, 32'd5, 3'd2, 1'b1, 1'b0);
        br("no_branch", 32'd5, 32'd5, 3'd0, 1'b0, 1'b0);

        id_ex = mk(32'h200, 32'h1000, 32'd0, 32'd8, 5'd8, 5'd0, 5'd2, 3'd2, 1'b0, 2'd0,
                   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("load", em(32'h200, 32'h1008, 32'd0, 5'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1));

        wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'd33;
        id_ex = mk(32'h204, 32'd7, 32'd0, 32'd0, 5'd2, 5'd0, 5'd9, 3'd0, 1'b0, 2'd2,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("load_use", em(32'h204, 32'd33, 32'd0, 5'd9, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        wb_we = 1'b0;

        id_ex = mk(32'h208, 32'd0, 32'd0, 32'd4, 5'd0, 5'd9, 5'd0, 3'd2, 1'b0, 2'd0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        held = em(32'h208, 32'd4, 32'd33, 5'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step("store_fwd", held);

        we = 1'b0;
        id_ex = mk(32'h300, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 2'd2,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step($sformatf("stall_%0d", i), held);

        we = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        chk32("flush_ctrl", {28'd0, ex_mem.RegWrite, ex_mem.MemRead, ex_mem.MemWrite,
                             ex_mem.MemToReg}, 32'd0);
        flush = 1'b0;

        step("post_flush", em(32'h300, 32'd12, 32'd7, 5'd3, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1));

        we = 1'b0; reset = 1'b1;
        step("reset_stall", '0);
        reset = 1'b0; we = 1'b1;
        id_ex = mk(32'h304, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 2'd2,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("post_reset", em(32'h304, 32'd3, 32'd2, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
